// File: rtl/bpu_pkg.sv
// Shared constants for the branch prediction unit: RISC-V control opcodes,
// branch funct3 codes and the 2-bit saturating counter encoding.
package bpu_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_t;

  function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    case (c)
      CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
      default: n = CTR_SNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// Conditional branch evaluation by funct3; funct3 010/011 are reserved
// encodings and report illegal with a not-taken outcome.
module branch_compare
  import bpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_data == rs2_data);
      F3_BNE:  taken = (rs1_data != rs2_data);
      F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: taken = (rs1_data <  rs2_data);
      F3_BGEU: taken = (rs1_data >= rs2_data);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters plus a one-cycle branch resolve path.
// Optional statistics counters are enabled by defining BPU_STATS_EN.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            flush,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_instr,
  input  logic [XLEN-1:0] res_pc,
  input  logic [XLEN-1:0] res_imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            res_pred_taken,
  input  logic [XLEN-1:0] res_pred_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            res_illegal
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  // Handshake: res_valid is a single-cycle request with no back-pressure;
  // flush squashes it, and redirect_valid/res_illegal pulse exactly one cycle later.

  logic             btb_valid [ENTRIES];
  logic [TAG_W-1:0] btb_tag   [ENTRIES];
  logic [XLEN-1:0]  btb_tgt   [ENTRIES];
  ctr_t             btb_ctr   [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx       = fetch_pc[IDX_W+1:2];
  assign f_tag       = fetch_pc[XLEN-1:IDX_W+2];
  assign f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign pred_taken  = f_hit && btb_ctr[f_idx][1];
  assign pred_target = pred_taken ? btb_tgt[f_idx] : fetch_pc + XLEN'(4);

  logic [6:0]       opcode;
  logic             is_branch, is_jal, is_jalr;
  logic             cmp_taken, cmp_illegal;
  logic             is_illegal, is_ctrl, act_taken, mispredict, accept;
  logic [XLEN-1:0]  act_target, next_pc;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;
  logic             wr_en, wr_tgt_en;
  ctr_t             wr_ctr;
  logic             unused_bits;

  assign unused_bits = ^{res_instr[31:15], res_instr[11:7], fetch_pc[1:0]};

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .funct3   (res_instr[14:12]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .taken    (cmp_taken),
    .illegal  (cmp_illegal)
  );

  assign opcode     = res_instr[6:0];
  assign is_branch  = (opcode == OP_BRANCH);
  assign is_jal     = (opcode == OP_JAL);
  assign is_jalr    = (opcode == OP_JALR);
  assign is_illegal = is_branch && cmp_illegal;
  assign is_ctrl    = (is_branch && !cmp_illegal) || is_jal || is_jalr;
  assign act_taken  = (is_branch && cmp_taken && !cmp_illegal) || is_jal || is_jalr;
  assign act_target = is_jalr ? ((rs1_data + res_imm) & ~XLEN'(1)) : res_pc + res_imm;
  assign next_pc    = act_taken ? act_target : res_pc + XLEN'(4);
  assign mispredict = is_ctrl && ((act_taken != res_pred_taken) ||
                      (act_taken && res_pred_taken && (act_target != res_pred_target)));
  assign accept     = res_valid && !flush;

  assign r_idx = res_pc[IDX_W+1:2];
  assign r_tag = res_pc[XLEN-1:IDX_W+2];
  assign r_hit = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);

  // Jumps always (re)claim the slot; branches allocate only when taken.
  always_comb begin
    wr_en     = 1'b0;
    wr_tgt_en = 1'b0;
    wr_ctr    = CTR_SNT;
    if (accept) begin
      if (is_jal || is_jalr) begin
        wr_en     = 1'b1;
        wr_tgt_en = 1'b1;
        wr_ctr    = CTR_ST;
      end else if (is_branch && !cmp_illegal) begin
        if (r_hit) begin
          wr_en     = 1'b1;
          wr_tgt_en = cmp_taken;
          wr_ctr    = ctr_step(btb_ctr[r_idx], cmp_taken);
        end else if (cmp_taken) begin
          wr_en     = 1'b1;
          wr_tgt_en = 1'b1;
          wr_ctr    = CTR_WT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_ctr[i]   <= CTR_SNT;
      end
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      res_illegal    <= 1'b0;
    end else begin
      redirect_valid <= accept && mispredict;
      res_illegal    <= accept && is_illegal;
      if (accept) redirect_pc <= next_pc;
      if (wr_en) begin
        btb_valid[r_idx] <= 1'b1;
        btb_ctr[r_idx]   <= wr_ctr;
      end
    end
  end

  // Tag and target carry no reset; the cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (!rst && wr_en)     btb_tag[r_idx] <= r_tag;
    if (!rst && wr_tgt_en) btb_tgt[r_idx] <= act_target;
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (accept && is_ctrl) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
